// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-word fetches to instruction
// memory, holds the fetched word for the controller and flags fetch timeouts.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | post-reset bubble, no request; always moves to FETCH
// FETCH | request pc from memory, count un-acked cycles
// HOLD  | instr valid and stable, wait for core to advance
// ERROR | memory never acked; sticky until reset

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcIn,
  input  logic [25:0] jumpAddr,
  input  logic [15:0] branchOffset,
  input  logic [31:0] regAddr,
  input  logic        advance,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchErr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_REG    = 2'd2;

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Last un-acked cycle index that is still tolerated before timing out.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_disp;
  logic [31:0] next_pc;
  logic        unused_reg_low;

  assign unused_reg_low = ^regAddr[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign branch_disp = {{14{branchOffset[15]}}, branchOffset, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pcIn)
      SEL_SEQ:  next_pc = pc_plus4;
      SEL_JUMP: next_pc = {pc_plus4[31:28], jumpAddr, 2'b00};
      SEL_REG:  next_pc = {regAddr[31:2], 2'b00};
      default:  next_pc = pc_plus4 + branch_disp;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        state_d    = ST_FETCH;
      end

      ST_FETCH: begin
        if (imemAck) begin
          instr_d       = imemData;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          instr_valid_d = 1'b0;
          fetch_err_d   = 1'b1;
          state_d       = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_HOLD: begin
        if (advance) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          wait_cnt_d    = '0;
          state_d       = ST_FETCH;
        end
      end

      default: begin
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b1;
        state_d       = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign imemReq    = (state_q == ST_FETCH);
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign instrValid = instr_valid_q;
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign fetchErr   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {pc, instr} pairs,
// a monitor pops and compares each time instrValid rises.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcIn;
  logic [25:0] jumpAddr;
  logic [15:0] branchOffset;
  logic [31:0] regAddr;
  logic        advance;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchErr;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] cur_pc;
  logic [31:0] last_instr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcIn         (pcIn),
    .jumpAddr     (jumpAddr),
    .branchOffset (branchOffset),
    .regAddr      (regAddr),
    .advance      (advance),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .instr        (instr),
    .instrValid   (instrValid),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .fetchErr     (fetchErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every new valid instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (instrValid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_capture: pc %h instr %h with nothing expected", pc, instr);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("capture_pc", pc, e[63:32]);
        chk("capture_instr", instr, e[31:0]);
      end
    end
    prev_valid = instrValid;
  end

  task automatic do_fetch(input int waits, input logic [31:0] data, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (imemReq !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1("fetch_req", imemReq, 1'b1);
    for (int i = 0; i < waits; i++) begin
      chk("fetch_addr_wait", imemAddr, exp_pc);
      @(negedge clk);
      chk1("fetch_req_wait", imemReq, 1'b1);
    end
    chk("fetch_addr", imemAddr, exp_pc);
    imemAck  = 1'b1;
    imemData = data;
    sb_q.push_back({exp_pc, data});
    @(negedge clk);
    imemAck  = 1'b0;
    imemData = 32'hBAD0_0000;
    chk1("hold_req", imemReq, 1'b0);
    cur_pc     = exp_pc;
    last_instr = data;
  endtask

  task automatic do_advance(input logic [1:0] sel, input logic [25:0] ja, input logic [15:0] bo,
                            input logic [31:0] ra, input logic [31:0] exp_pc);
    chk("pc_plus4", pcPlus4, cur_pc + 32'd4);
    // A stray ack while holding must not disturb the held instruction.
    imemAck  = 1'b1;
    imemData = 32'hFFFF_0000;
    @(negedge clk);
    imemAck  = 1'b0;
    chk("hold_instr", instr, last_instr);
    chk1("hold_valid", instrValid, 1'b1);
    pcIn         = sel;
    jumpAddr     = ja;
    branchOffset = bo;
    regAddr      = ra;
    advance      = 1'b1;
    @(negedge clk);
    advance      = 1'b0;
    pcIn         = ~sel;
    jumpAddr     = ~ja;
    branchOffset = ~bo;
    regAddr      = ~ra;
    chk("adv_pc", pc, exp_pc);
    chk("adv_addr", imemAddr, exp_pc);
    chk1("adv_req", imemReq, 1'b1);
    chk1("adv_valid", instrValid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b0;
    pcIn         = 2'd0;
    jumpAddr     = '0;
    branchOffset = '0;
    regAddr      = '0;
    advance      = 1'b0;
    imemAck      = 1'b0;
    imemData     = '0;
    cur_pc       = '0;
    last_instr   = '0;

    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_valid", instrValid, 1'b0);
    chk1("rst_err", fetchErr, 1'b0);
    chk1("rst_req", imemReq, 1'b0);
    rst = 1'b1;

    do_fetch(0, 32'h2008_0005, 32'h0000_0000);

    do_advance(2'd2, 26'h0, 16'h0, 32'h0000_0040, 32'h0000_0040);
    do_fetch(0, 32'h1111_0001, 32'h0000_0040);
    do_advance(2'd3, 26'h0, 16'hFFFE, 32'h0, 32'h0000_003C);
    do_fetch(1, 32'h1111_0002, 32'h0000_003C);
    do_advance(2'd2, 26'h0, 16'h0, 32'h0000_0040, 32'h0000_0040);
    do_fetch(0, 32'h1111_0003, 32'h0000_0040);
    do_advance(2'd3, 26'h0, 16'h0003, 32'h0, 32'h0000_0050);
    do_fetch(3, 32'h1111_0004, 32'h0000_0050);
    do_advance(2'd2, 26'h0, 16'h0, 32'h1000_0008, 32'h1000_0008);
    do_fetch(0, 32'h1111_0005, 32'h1000_0008);
    do_advance(2'd1, 26'h000_0100, 16'h0, 32'h0, 32'h1000_0400);
    do_fetch(2, 32'h1111_0006, 32'h1000_0400);
    do_advance(2'd2, 26'h0, 16'h0, 32'h0000_1237, 32'h0000_1234);
    do_fetch(0, 32'h1111_0007, 32'h0000_1234);
    do_advance(2'd0, 26'h0, 16'h0, 32'h0, 32'h0000_1238);
    do_fetch(1, 32'h1111_0008, 32'h0000_1238);
    do_advance(2'd2, 26'h0, 16'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    do_fetch(0, 32'h1111_0009, 32'hFFFF_FFFC);
    do_advance(2'd0, 26'h0, 16'h0, 32'h0, 32'h0000_0000);
    do_fetch(0, 32'h1111_000A, 32'h0000_0000);

    // advance during FETCH ignored, then reset with a concurrent ack
    do_advance(2'd2, 26'h0, 16'h0, 32'h0000_0200, 32'h0000_0200);
    pcIn    = 2'd2;
    regAddr = 32'h0000_0500;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    chk("fetch_adv_pc", pc, 32'h0000_0200);
    chk("fetch_adv_addr", imemAddr, 32'h0000_0200);
    rst      = 1'b0;
    imemAck  = 1'b1;
    imemData = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_pc", pc, 32'h0);
    chk1("midrst_valid", instrValid, 1'b0);
    chk1("midrst_req", imemReq, 1'b0);
    chk("midrst_instr", instr, 32'h0);
    @(negedge clk);
    imemAck = 1'b0;
    chk1("postrst_valid", instrValid, 1'b0);
    chk("postrst_instr", instr, 32'h0);
    chk1("postrst_req", imemReq, 1'b1);
    chk("postrst_addr", imemAddr, 32'h0);
    do_fetch(0, 32'h2222_0001, 32'h0000_0000);

    // timeout: memory never acks
    do_advance(2'd0, 26'h0, 16'h0, 32'h0, 32'h0000_0004);
    n = 0;
    while (imemReq === 1'b1 && n < 40) begin
      chk("timeout_addr", imemAddr, 32'h0000_0004);
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 32'd15);
    chk1("err_flag", fetchErr, 1'b1);
    chk1("err_req", imemReq, 1'b0);
    chk1("err_valid", instrValid, 1'b0);
    imemAck  = 1'b1;
    imemData = 32'h3333_0001;
    advance  = 1'b1;
    repeat (3) @(negedge clk);
    imemAck = 1'b0;
    advance = 1'b0;
    chk1("err_sticky", fetchErr, 1'b1);
    chk1("err_sticky_req", imemReq, 1'b0);
    chk1("err_sticky_valid", instrValid, 1'b0);
    chk("err_sticky_pc", pc, 32'h0000_0004);

    rst = 1'b0;
    @(negedge clk);
    chk1("err_rst_flag", fetchErr, 1'b0);
    chk("err_rst_pc", pc, 32'h0);
    rst = 1'b1;
    do_fetch(0, 32'h4444_0001, 32'h0000_0000);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of first instruction fetched after reset.
REQ-002 Parameter: MAX_WAIT, default 15, number of un-acked fetch cycles before a fetch error is raised.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 pcIn  input  2  next-PC select from main controller: 0 sequential, 1 jump, 2 register jump, 3 taken branch.
REQ-006 jumpAddr  input  26  instruction target field for pcIn=1.
REQ-007 branchOffset  input  16  signed word offset for pcIn=3.
REQ-008 regAddr  input  32  register target for pcIn=2.
REQ-009 advance  input  1  core has finished the current instruction; commit the next PC.
REQ-010 imemReq  output  1  fetch request to instruction memory.
REQ-011 imemAddr  output  32  fetch address, equals pc.
REQ-012 imemAck  input  1  memory returns valid imemData this cycle.
REQ-013 imemData  input  32  fetched instruction word.
REQ-014 instr  output  32  registered current instruction, feeds controller opcode decode.
REQ-015 instrValid  output  1  instr holds a valid, not-yet-committed instruction.
REQ-016 pc  output  32  address of current instruction.
REQ-017 pcPlus4  output  32  pc+4, combinational, used as link value.
REQ-018 fetchErr  output  1  sticky fetch-timeout flag.

Function
REQ-019 The block SHALL implement states IDLE, FETCH, HOLD, ERROR.
REQ-020 IDLE: imemReq=0; next cycle unconditionally FETCH.
REQ-021 FETCH: imemReq=1, imemAddr=pc held stable until ack; on imemAck, instr<=imemData, instrValid<=1, go HOLD.
REQ-022 Ack in the first FETCH cycle (zero wait) SHALL be accepted.
REQ-023 A wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; on reaching MAX_WAIT without ack, go ERROR.
REQ-024 HOLD: imemReq=0, instr stable; on advance, pc<=nextPC, instrValid<=0, go FETCH.
REQ-025 advance in IDLE, FETCH or ERROR SHALL be ignored; imemAck outside FETCH SHALL be ignored.
REQ-026 ERROR: imemReq=0, fetchErr=1, instrValid=0; exit only via reset.
REQ-027 nextPC for pcIn=0 SHALL be pcPlus4.
REQ-028 nextPC for pcIn=1 SHALL be {pcPlus4[31:28], jumpAddr, 2'b00}.
REQ-029 nextPC for pcIn=2 SHALL be {regAddr[31:2], 2'b00}.
REQ-030 nextPC for pcIn=3 SHALL be pcPlus4 + (sign-extended branchOffset << 2).
REQ-031 All PC arithmetic SHALL be 32-bit modulo 2^32 (pc=32'hFFFF_FFFC, pcIn=0 -> 0).
REQ-032 nextPC SHALL be sampled only in the advance cycle; later pcIn changes SHALL not affect pc.
REQ-033 Latency: advance in cycle n -> pc updated and imemReq=1 in cycle n+1; minimum 2 cycles per instruction with zero-wait memory.
REQ-034 pc[1:0] SHALL always be 2'b00.

Reset
REQ-035 With rst=0 at a rising edge: pc=RESET_PC, instr=0, instrValid=0, fetchErr=0, wait counter=0, state IDLE; imemReq=0 from the following cycle.
REQ-036 Reset mid-fetch SHALL abandon the request; an ack arriving during or in the first cycle after reset SHALL be ignored.
REQ-037 First fetch after reset release SHALL address RESET_PC.

Verification
REQ-038 Reset release, ack in first FETCH cycle with 32'h2008_0005 -> imemAddr=0, instr=32'h2008_0005, instrValid=1 next cycle.
REQ-039 pc=32'h0000_0040, pcIn=3, branchOffset=16'hFFFE, advance -> pc=32'h0000_003C; with branchOffset=16'h0003 -> pc=32'h0000_0050.
REQ-040 pc=32'h1000_0008, pcIn=1, jumpAddr=26'h000_0100, advance -> pc=32'h1000_0400; pcIn=2, regAddr=32'h0000_1237 -> pc=32'h0000_1234.
REQ-041 Memory withholds ack for 3 cycles -> imemReq and imemAddr stable for 4 cycles, capture on 4th; withhold MAX_WAIT cycles -> fetchErr=1, imemReq=0 until reset.
REQ-042 advance pulsed during FETCH, then rst=0 during FETCH with simultaneous ack -> pc unchanged by advance; after reset pc=RESET_PC, instrValid=0.
